// File: rtl/axis_seq_pkg.sv
// Shared types and constants for the AXIS burst sequencer.
// State encoding, config field layout and synchroniser depth default.
package axis_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BURST,
    ST_GAP,
    ST_HOLD
  } state_t;

  localparam int CFG_FIELDS = 3;

  // Field slots inside the config word, LSB slot first.
  localparam int NB_FLD  = 0;
  localparam int GAP_FLD = 1;
  localparam int BL_FLD  = 2;

  localparam int SYNC_DEF = 2;

  function automatic int fld_lo(input int fld, input int w);
    return fld * w;
  endfunction

endpackage

// File: rtl/cfg_serial_loader.sv
// Serial config front end: synchronises sclk/sdata/load into clk,
// shifts shadow MSB first on sclk rise, strobes load_stb on load rise.
module cfg_serial_loader
  import axis_seq_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int SYNC_STAGES = SYNC_DEF
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        cfg_sclk,
  input  logic                        cfg_sdata,
  input  logic                        cfg_load,
  output logic [CFG_FIELDS*CNT_W-1:0] shadow,
  output logic                        load_stb
);

  localparam int CW = CFG_FIELDS * CNT_W;
  localparam int SM = SYNC_STAGES - 1;

  logic [SM:0] sclk_q;
  logic [SM:0] sdat_q;
  logic [SM:0] load_q;
  logic        sclk_d;
  logic        load_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sclk_q <= '0;
      sdat_q <= '0;
      load_q <= '0;
      sclk_d <= 1'b0;
      load_d <= 1'b0;
      shadow <= '0;
    end else begin
      sclk_q <= {sclk_q[SM-1:0], cfg_sclk};
      sdat_q <= {sdat_q[SM-1:0], cfg_sdata};
      load_q <= {load_q[SM-1:0], cfg_load};
      sclk_d <= sclk_q[SM];
      load_d <= load_q[SM];
      // sdata has the same sync depth as sclk, so they stay aligned.
      if (sclk_q[SM] && !sclk_d)
        shadow <= {shadow[CW-2:0], sdat_q[SM]};
    end
  end

  assign load_stb = load_q[SM] & ~load_d;

endmodule

// File: rtl/axis_burst_sequencer.sv
// Gates AXIS bursts from source to DAC: trigger starts num_bursts bursts
// of burst_len accepted beats separated by gap_len idle cycles.
// Ports: clk/reset, cfg_* serial config, trig_*, cont_mode, flush,
// s_axis_* source side, m_axis_* sink side, busy, done pulse.
module axis_burst_sequencer
  import axis_seq_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int DATA_W      = 256,
  parameter int SYNC_STAGES = SYNC_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_sclk,
  input  logic              cfg_sdata,
  input  logic              cfg_load,
  input  logic              trig_gpio,
  input  logic              trig_ext,
  input  logic              cont_mode,
  input  logic              flush,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tlast,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              busy,
  output logic              done
);

  localparam int CW = CFG_FIELDS * CNT_W;
  localparam int SM = SYNC_STAGES - 1;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CW-1:0] shadow;
  logic [CW-1:0] active;
  logic          load_stb;
  logic          load_pending;

  logic [SM:0] tg_q;
  logic [SM:0] te_q;
  logic        trig_any;
  logic        trig_prev;
  logic        trig_rise;

  state_t           state, state_n;
  logic [CNT_W-1:0] beat_cnt, beat_n;
  logic [CNT_W-1:0] burst_cnt, burst_n;
  logic [CNT_W-1:0] gap_cnt, gap_n;
  logic             cont_q, cont_n;

  logic [CNT_W-1:0] burst_len, gap_len, num_bursts;
  logic [CNT_W-1:0] bl_eff, nb_eff;
  logic             open, beat;
  logic             unused_tlast;

  assign unused_tlast = s_axis_tlast;

  cfg_serial_loader #(
    .CNT_W       (CNT_W),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_loader (
    .clk       (clk),
    .reset     (reset),
    .cfg_sclk  (cfg_sclk),
    .cfg_sdata (cfg_sdata),
    .cfg_load  (cfg_load),
    .shadow    (shadow),
    .load_stb  (load_stb)
  );

  assign burst_len  = active[fld_lo(BL_FLD, CNT_W)  +: CNT_W];
  assign gap_len    = active[fld_lo(GAP_FLD, CNT_W) +: CNT_W];
  assign num_bursts = active[fld_lo(NB_FLD, CNT_W)  +: CNT_W];
  assign bl_eff = (burst_len == '0)  ? ONE : burst_len;
  assign nb_eff = (num_bursts == '0) ? ONE : num_bursts;

  assign open          = (state == ST_BURST);
  assign beat          = s_axis_tvalid & m_axis_tready;
  assign s_axis_tready = open & m_axis_tready;
  assign m_axis_tvalid = open & s_axis_tvalid;
  assign m_axis_tdata  = flush ? '0 : s_axis_tdata;
  assign busy          = (state != ST_IDLE);
  assign trig_rise     = trig_any & ~trig_prev;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (&v) ? v : v + ONE;
  endfunction

  // Extra flop after the OR gives the documented trigger latency.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tg_q      <= '0;
      te_q      <= '0;
      trig_any  <= 1'b0;
      trig_prev <= 1'b0;
    end else begin
      tg_q      <= {tg_q[SM-1:0], trig_gpio};
      te_q      <= {te_q[SM-1:0], trig_ext};
      trig_any  <= tg_q[SM] | te_q[SM];
      trig_prev <= trig_any;
    end
  end

  // Active config only changes in IDLE; loads arriving mid-sequence wait.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active       <= '0;
      load_pending <= 1'b0;
    end else if (state == ST_IDLE && (load_stb || load_pending)) begin
      active       <= shadow;
      load_pending <= 1'b0;
    end else if (load_stb) begin
      load_pending <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      beat_cnt  <= '0;
      burst_cnt <= '0;
      gap_cnt   <= '0;
      cont_q    <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      beat_cnt  <= beat_n;
      burst_cnt <= burst_n;
      gap_cnt   <= gap_n;
      cont_q    <= cont_n;
      done      <= (state_n == ST_HOLD) && (state != ST_HOLD);
    end
  end

  always_comb begin
    state_n = state;
    beat_n  = beat_cnt;
    burst_n = burst_cnt;
    gap_n   = gap_cnt;
    cont_n  = cont_q;
    unique case (state)
      ST_IDLE: begin
        if (trig_rise) begin
          state_n = ST_BURST;
          beat_n  = '0;
          burst_n = '0;
          cont_n  = cont_mode;
        end
      end
      ST_BURST: begin
        if (cont_q) begin
          if (beat)
            beat_n = sat_inc(beat_cnt);
          if (!trig_any)
            state_n = ST_HOLD;
        end else if (beat) begin
          if (beat_cnt >= bl_eff - ONE) begin
            if (burst_cnt < nb_eff - ONE) begin
              burst_n = sat_inc(burst_cnt);
              beat_n  = '0;
              gap_n   = '0;
              state_n = (gap_len == '0) ? ST_BURST : ST_GAP;
            end else begin
              state_n = ST_HOLD;
            end
          end else begin
            beat_n = sat_inc(beat_cnt);
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt >= gap_len - ONE)
          state_n = ST_BURST;
        else
          gap_n = sat_inc(gap_cnt);
      end
      ST_HOLD: begin
        if (!trig_any)
          state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_axis_burst_sequencer.sv
// Directed bench for axis_burst_sequencer.
// Hand-computed beat counts, open/gap patterns and trigger latency.
module tb_axis_burst_sequencer;

  localparam int CNT_W  = 32;
  localparam int DATA_W = 256;

  logic              clk = 1'b0;
  logic              reset;
  logic              cfg_sclk, cfg_sdata, cfg_load;
  logic              trig_gpio, trig_ext, cont_mode, flush;
  logic              s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic [DATA_W-1:0] s_axis_tdata, m_axis_tdata;
  logic              m_axis_tvalid, m_axis_tready;
  logic              busy, done;

  int          errs = 0;
  int          checks = 0;
  int          beats = 0;
  int          dones = 0;
  int          viol_rdy = 0;
  int          viol_fl = 0;
  int          tr_len = 0;
  logic [63:0] tr = '0;
  logic        tog = 1'b0;

  axis_burst_sequencer #(
    .CNT_W  (CNT_W),
    .DATA_W (DATA_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .cfg_sclk      (cfg_sclk),
    .cfg_sdata     (cfg_sdata),
    .cfg_load      (cfg_load),
    .trig_gpio     (trig_gpio),
    .trig_ext      (trig_ext),
    .cont_mode     (cont_mode),
    .flush         (flush),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  // Inputs change at posedge+1, so negedge sees the values
  // that the following posedge will act on.
  always @(negedge clk) begin
    if (m_axis_tvalid && m_axis_tready) beats <= beats + 1;
    if (done) dones <= dones + 1;
    if (s_axis_tready && !m_axis_tready) viol_rdy <= viol_rdy + 1;
    if (flush && m_axis_tvalid && m_axis_tdata != '0)
      viol_fl <= viol_fl + 1;
    if (busy) begin
      tr     <= {tr[62:0], m_axis_tvalid};
      tr_len <= tr_len + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (tog) m_axis_tready = ~m_axis_tready;
    end
  endtask

  task automatic shift_cfg(input logic [31:0] bl, input logic [31:0] gl,
                           input logic [31:0] nb);
    logic [95:0] w;
    w = {bl, gl, nb};
    for (int i = 95; i >= 0; i--) begin
      cfg_sdata = w[i];
      run_cycles(4);
      cfg_sclk = 1'b1;
      run_cycles(4);
      cfg_sclk = 1'b0;
    end
  endtask

  task automatic pulse_load();
    cfg_load = 1'b1;
    run_cycles(4);
    cfg_load = 1'b0;
    run_cycles(6);
  endtask

  task automatic run_seq(input string tag, input int post, input bit ld,
                         input int exp_beats, input int exp_len,
                         input logic [63:0] exp_pat);
    int b0, d0, l0, n;
    b0 = beats;
    d0 = dones;
    l0 = tr_len;
    trig_gpio = 1'b1;
    run_cycles(1);
    trig_gpio = 1'b0;
    run_cycles(2);
    chk({tag, "_lat_pre"}, 64'(m_axis_tvalid), 64'd0);
    run_cycles(1);
    chk({tag, "_lat"}, 64'(m_axis_tvalid), 64'd1);
    if (ld) begin
      cfg_load = 1'b1;
      run_cycles(2);
      cfg_load = 1'b0;
    end
    run_cycles(post);
    chk({tag, "_beats"}, 64'(beats - b0), 64'(exp_beats));
    chk({tag, "_done"}, 64'(dones - d0), 64'd1);
    chk({tag, "_idle"}, 64'(busy), 64'd0);
    n = tr_len - l0;
    if (exp_len > 0) begin
      chk({tag, "_len"}, 64'(n), 64'(exp_len));
      chk({tag, "_pat"}, tr & ((64'd1 << n) - 64'd1), exp_pat);
    end
  endtask

  initial begin
    int b0, d0, l0;
    reset = 1'b0;
    cfg_sclk = 1'b0;
    cfg_sdata = 1'b0;
    cfg_load = 1'b0;
    trig_gpio = 1'b0;
    trig_ext = 1'b0;
    cont_mode = 1'b0;
    flush = 1'b0;
    s_axis_tvalid = 1'b1;
    s_axis_tlast = 1'b0;
    s_axis_tdata = {8{32'h1234_5678}};
    m_axis_tready = 1'b1;
    run_cycles(3);
    chk("rst_tready", 64'(s_axis_tready), 64'd0);
    chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    reset = 1'b1;
    run_cycles(3);

    shift_cfg(4, 2, 3);
    pulse_load();
    run_seq("seq", 30, 1'b0, 12, 17, 64'b1111_00_1111_00_1111_0);

    tog = 1'b1;
    run_seq("tog", 60, 1'b0, 12, 0, 64'd0);
    tog = 1'b0;
    m_axis_tready = 1'b1;
    chk("tog_noready", 64'(viol_rdy), 64'd0);

    b0 = beats;
    d0 = dones;
    l0 = tr_len;
    cont_mode = 1'b1;
    trig_ext = 1'b1;
    run_cycles(20);
    trig_gpio = 1'b1;
    run_cycles(2);
    trig_gpio = 1'b0;
    run_cycles(28);
    trig_ext = 1'b0;
    run_cycles(10);
    cont_mode = 1'b0;
    chk("cont_beats", 64'(beats - b0), 64'd50);
    chk("cont_done", 64'(dones - d0), 64'd1);
    chk("cont_idle", 64'(busy), 64'd0);
    chk("cont_len", 64'(tr_len - l0), 64'd51);
    chk("cont_pat", tr & ((64'd1 << 51) - 64'd1),
        ((64'd1 << 50) - 64'd1) << 1);

    shift_cfg(8, 0, 1);
    run_seq("old", 30, 1'b1, 12, 17, 64'b1111_00_1111_00_1111_0);
    run_seq("new", 20, 1'b0, 8, 9, 64'b1111_1111_0);

    b0 = beats;
    s_axis_tdata = {8{32'hA5A5_0001}};
    trig_gpio = 1'b1;
    run_cycles(1);
    trig_gpio = 1'b0;
    run_cycles(4);
    chk("fl_pass", m_axis_tdata[63:0], 64'hA5A5_0001_A5A5_0001);
    flush = 1'b1;
    #1;
    chk("fl_zero", m_axis_tdata[63:0], 64'd0);
    chk("fl_valid", 64'(m_axis_tvalid), 64'd1);
    run_cycles(20);
    flush = 1'b0;
    chk("fl_beats", 64'(beats - b0), 64'd8);
    chk("fl_viol", 64'(viol_fl), 64'd0);

    trig_gpio = 1'b1;
    run_cycles(1);
    trig_gpio = 1'b0;
    run_cycles(4);
    chk("rst_mid_open", 64'(s_axis_tready), 64'd1);
    reset = 1'b0;
    #1;
    chk("rst_mid_tready", 64'(s_axis_tready), 64'd0);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    run_cycles(3);
    reset = 1'b1;
    run_cycles(3);

    shift_cfg(0, 0, 0);
    pulse_load();
    run_seq("zero", 10, 1'b0, 1, 2, 64'b10);

    shift_cfg(2, 0, 2);
    pulse_load();
    run_seq("b2b", 10, 1'b0, 4, 5, 64'b1111_0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
